// File: rtl/switch_capture_pkg.sv
// Shared types and constants for the switch input capture path.
package switch_capture_pkg;

    // Handshake state: no pending word, or a word waiting for the controller
    typedef enum logic {IDLE, PEND} cap_state_t;

    // Bit positions inside error_vector
    localparam int unsigned ERR_OVERRUN = 0;
    localparam int unsigned ERR_CHATTER = 1;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, debounce counter, stable level and chatter pulse.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic flip,
    output logic chatter
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DEBOUNCE_CYCLES / 2);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter next state, flip decision and chatter detection
    always_comb begin
        cnt_d   = cnt_q;
        flip    = 1'b0;
        chatter = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
            // Input fell back after holding off-level for a long stretch
            if (cnt_q >= CNT_HALF) begin
                chatter = 1'b1;
            end
        end else if (cnt_q == CNT_LAST) begin
            flip  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser chain, counter and stable level registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_q ^ flip;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/switch_input_capture.sv
// Debounced switch capture: per-bit debouncers, change-event handshake and sticky errors.
module switch_input_capture
    import switch_capture_pkg::*;
#(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch_array,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] stable_value,
    input  logic             err_clear,
    output logic [7:0]       error_vector
);

    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] chatter;
    logic [WIDTH-1:0] new_stable;
    logic             change_evt;

    cap_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [1:0]       err_q, err_d;
    logic             overrun;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk    (clk),
            .rst    (rst),
            .raw    (switch_array[i]),
            .stable (stable_value[i]),
            .flip   (flip[i]),
            .chatter(chatter[i])
        );
    end

    // Bits flipping on the same edge form a single event
    assign change_evt = |flip;
    assign new_stable = stable_value ^ flip;

    // Handshake next state and sticky error update
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        overrun = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (change_evt) begin
                    state_d = PEND;
                    data_d  = new_stable;
                    valid_d = 1'b1;
                end
            end
            PEND: begin
                if (change_evt) begin
                    // Newest word wins; losing an unconsumed word is an overrun
                    data_d  = new_stable;
                    overrun = ~out_ready;
                end else if (out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = err_clear ? 2'b00 : err_q;
        // New errors take priority over a simultaneous clear
        if (overrun) begin
            err_d[ERR_OVERRUN] = 1'b1;
        end
        if (|chatter) begin
            err_d[ERR_CHATTER] = 1'b1;
        end
    end

    // Handshake, output word and error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_data     = data_q;
    assign out_valid    = valid_q;
    assign error_vector = {6'b000000, err_q};

endmodule

// File: tb/tb_switch_input_capture.sv
// Directed self-checking bench for switch_input_capture with DEBOUNCE_CYCLES = 4.
module tb_switch_input_capture;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEB   = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] switch_array;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] stable_value;
    logic             err_clear;
    logic [7:0]       error_vector;

    int               n_checks;
    int               n_errors;
    int               xfers;
    logic [WIDTH-1:0] last_xfer;
    int               seen;

    switch_input_capture #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .switch_array(switch_array),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .stable_value(stable_value),
        .err_clear   (err_clear),
        .error_vector(error_vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; record any handshake completing on this edge
    task automatic tick();
        if (out_valid && out_ready) begin
            xfers++;
            last_xfer = out_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        xfers        = 0;
        last_xfer    = '0;
        rst          = 1'b1;
        switch_array = '0;
        out_ready    = 1'b0;
        err_clear    = 1'b0;
        ticks(3);
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_stable", 32'(stable_value), 32'h0);
        check("rst_err", 32'(error_vector), 32'h0);

        // Clean rise of bit 0: accepted exactly 6 edges later
        switch_array = 16'h0001;
        ticks(5);
        check("t2_stable_early", 32'(stable_value), 32'h0);
        check("t2_valid_early", 32'(out_valid), 32'h0);
        tick();
        check("t2_stable", 32'(stable_value), 32'h0001);
        check("t2_valid", 32'(out_valid), 32'h1);
        check("t2_data", 32'(out_data), 32'h0001);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_valid_drop", 32'(out_valid), 32'h0);
        check("t2_xfers", 32'(xfers), 32'd1);
        check("t2_xfer_data", 32'(last_xfer), 32'h0001);

        // Bit 3 chatters with a 4-cycle period
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            switch_array = 16'h0009;
            for (int j = 0; j < 2; j++) begin
                tick();
                if (out_valid) seen++;
            end
            switch_array = 16'h0001;
            for (int j = 0; j < 2; j++) begin
                tick();
                if (out_valid) seen++;
            end
        end
        for (int j = 0; j < 8; j++) begin
            tick();
            if (out_valid) seen++;
        end
        check("t3_no_valid", 32'(seen), 32'd0);
        check("t3_stable", 32'(stable_value), 32'h0001);
        check("t3_err", 32'(error_vector), 32'h02);

        // Asynchronous reset between clock edges
        switch_array = 16'h0000;
        #3;
        rst = 1'b1;
        #1;
        check("t1_async_stable", 32'(stable_value), 32'h0);
        check("t1_async_data", 32'(out_data), 32'h0);
        check("t1_async_valid", 32'(out_valid), 32'h0);
        check("t1_async_err", 32'(error_vector), 32'h0);
        ticks(2);
        rst = 1'b0;
        seen = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (out_valid) seen++;
        end
        check("t1_no_event", 32'(seen), 32'd0);

        // Coalescing overrun while the controller stalls
        switch_array = 16'h00F0;
        ticks(6);
        check("t4_first_valid", 32'(out_valid), 32'h1);
        check("t4_first_data", 32'(out_data), 32'h00F0);
        ticks(2);
        switch_array = 16'h0F00;
        seen = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (!out_valid || out_data !== 16'h00F0) seen++;
        end
        check("t4_held", 32'(seen), 32'd0);
        tick();
        check("t4_data", 32'(out_data), 32'h0F00);
        check("t4_valid", 32'(out_valid), 32'h1);
        check("t4_err", 32'(error_vector), 32'h01);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t4_err_clr", 32'(error_vector), 32'h00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_drain", 32'(out_valid), 32'h0);

        // Ready coincides with a new event: old word moves, new word pending
        switch_array = 16'h0001;
        ticks(6);
        check("t5_pend_data", 32'(out_data), 32'h0001);
        switch_array = 16'h0003;
        ticks(5);
        xfers = 0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t5_xfers", 32'(xfers), 32'd1);
        check("t5_xfer_data", 32'(last_xfer), 32'h0001);
        check("t5_data", 32'(out_data), 32'h0003);
        check("t5_valid", 32'(out_valid), 32'h1);
        check("t5_err", 32'(error_vector), 32'h00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset pulse in the middle of a debounce
        switch_array = 16'hFFFF;
        ticks(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        xfers = 0;
        ticks(5);
        check("t6_valid_early", 32'(out_valid), 32'h0);
        tick();
        check("t6_valid", 32'(out_valid), 32'h1);
        check("t6_data", 32'(out_data), 32'hFFFF);
        ticks(10);
        check("t6_still_data", 32'(out_data), 32'hFFFF);
        check("t6_no_overrun", 32'(error_vector), 32'h00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        ticks(3);
        check("t6_xfers", 32'(xfers), 32'd1);
        check("t6_idle", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
